// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-add sequential multiplier, n iterations of one ripple adder
// Optional signed mode: define SEQ_MULT_SIGNED_EN to add isSigned and the NEG fix-up state.

module seq_mult_adder #(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);

  logic [n:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < n; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[n];

endmodule

module seq_multiplier #(
  parameter int n = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic           isSigned,
`endif
  input  logic [n-1:0]   A,
  input  logic [n-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] Product
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [n-1:0]   ZERO_N  = '0;
  localparam logic [2*n-1:0] ZERO_2N = '0;
  localparam logic [CW-1:0]  LAST    = CW'(n - 1);

  typedef enum logic [1:0] {IDLE, RUN, NEG, DONE} state_t;

  state_t           state_q, state_d;
  logic [n-1:0]     mcand_q, mcand_d;
  logic [n-1:0]     mplier_q, mplier_d;
  logic [n-1:0]     acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2*n-1:0]   product_q, product_d;
`ifdef SEQ_MULT_SIGNED_EN
  logic             neg_q, neg_d;
  logic             sgn_q, sgn_d;
`endif

  logic [n-1:0]     sum;
  logic             cout;

  seq_mult_adder #(.n(n)) u_adder (
    .a    (acc_q),
    .b    (mcand_q),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q     <= 1'b0;
      sgn_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q     <= neg_d;
      sgn_q     <= sgn_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
`ifdef SEQ_MULT_SIGNED_EN
    neg_d     = neg_q;
    sgn_d     = sgn_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = A;
          mplier_d = B;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
`ifdef SEQ_MULT_SIGNED_EN
          sgn_d    = isSigned;
          neg_d    = 1'b0;
          if (isSigned) begin
            // Multiply magnitudes; the most-negative value maps onto 2^(n-1) unsigned.
            if (A[n-1]) mcand_d  = ZERO_N - A;
            if (B[n-1]) mplier_d = ZERO_N - B;
            neg_d = A[n-1] ^ B[n-1];
          end
`endif
        end
      end
      RUN: begin
        // Product's low half shifts into mplier as multiplier bits are consumed.
        if (mplier_q[0]) {acc_d, mplier_d} = {cout, sum, mplier_q[n-1:1]};
        else             {acc_d, mplier_d} = {1'b0, acc_q, mplier_q[n-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
`ifdef SEQ_MULT_SIGNED_EN
          if (sgn_q) begin
            state_d = NEG;
          end else begin
            state_d   = DONE;
            product_d = {acc_d, mplier_d};
          end
`else
          state_d   = DONE;
          product_d = {acc_d, mplier_d};
`endif
        end
      end
      NEG: begin
`ifdef SEQ_MULT_SIGNED_EN
        if (neg_q) {acc_d, mplier_d} = ZERO_2N - {acc_q, mplier_q};
`endif
        state_d   = DONE;
        product_d = {acc_d, mplier_d};
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q == RUN) || (state_q == NEG);
  assign done    = (state_q == DONE);
  assign Product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - randomized self-checking bench for seq_multiplier
// Signed cases are exercised only when SEQ_MULT_SIGNED_EN is defined.

module tb_seq_multiplier;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  a_r = '0;
  logic [N-1:0]  b_r = '0;
  logic          busy;
  logic          done;
  logic [2*N-1:0] product;
`ifdef SEQ_MULT_SIGNED_EN
  logic          is_signed = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.n(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef SEQ_MULT_SIGNED_EN
    .isSigned (is_signed),
`endif
    .A        (a_r),
    .B        (b_r),
    .busy     (busy),
    .done     (done),
    .Product  (product)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge just after the accepting edge E0.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit sgn, input bit hold);
    @(negedge clk);
    a_r   = a;
    b_r   = b;
    start = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
    is_signed = sgn;
`else
    if (sgn) $display("signed request ignored in unsigned build");
`endif
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Counts rising edges after E0 until done is seen; returns in the done cycle.
  task automatic wait_done(input bit scramble, output int lat);
    bit ovl;
    lat = 0;
    ovl = busy && done;
    while (done !== 1'b1 && lat < 200) begin
      if (scramble) begin
        a_r = $urandom;
        b_r = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (busy && done) ovl = 1'b1;
    end
    check("busy_done_overlap", 64'(ovl), 64'd0);
    if (lat >= 200) check("done_timeout", 64'(done), 64'd1);
  endtask

  function automatic logic [63:0] ref_u(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [63:0] wa, wb;
    wa = 64'(a);
    wb = 64'(b);
    return wa * wb;
  endfunction

  initial begin
    int lat;
    logic [N-1:0] ra, rb;
    bit seen;

    #1 rst_n = 1'b0;
    #2;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    launch(32'd3, 32'd5, 1'b0, 1'b0);
    check("busy_after_start", 64'(busy), 64'd1);
    wait_done(1'b0, lat);
    check("lat_3x5", 64'(lat), 64'(N));
    check("prod_3x5", product, 64'h0000_0000_0000_000F);
    @(negedge clk);
    check("idle_after_done", 64'(done), 64'd0);
    check("hold_3x5", product, 64'h0000_0000_0000_000F);

    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done(1'b0, lat);
    check("prod_max", product, 64'hFFFF_FFFE_0000_0001);

    // start held high with changing operands: only the first and the post-IDLE start count
    launch(32'h1234_5678, 32'd0, 1'b0, 1'b1);
    wait_done(1'b1, lat);
    check("lat_b0", 64'(lat), 64'(N));
    check("prod_b0", product, 64'd0);
    a_r = 32'd6;
    b_r = 32'd7;
    @(posedge clk);
    @(negedge clk);
    check("idle_busy_after_held", 64'(busy), 64'd0);
    check("idle_hold_prod", product, 64'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("held_start_accepted", 64'(busy), 64'd1);
    wait_done(1'b0, lat);
    check("prod_6x7", product, 64'd42);

    launch(32'd7, 32'd9, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", product, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("no_done_after_abort", 64'(seen), 64'd0);
    launch(32'd2, 32'd2, 1'b0, 1'b0);
    wait_done(1'b0, lat);
    check("prod_2x2", product, 64'd4);

`ifdef SEQ_MULT_SIGNED_EN
    launch(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0);
    wait_done(1'b0, lat);
    check("lat_signed", 64'(lat), 64'(N + 1));
    check("prod_m3x7", product, 64'hFFFF_FFFF_FFFF_FFEB);
    launch(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    wait_done(1'b0, lat);
    check("prod_minmin", product, 64'h4000_0000_0000_0000);
    for (int i = 0; i < 50; i++) begin
      ra = $urandom;
      rb = $urandom;
      launch(ra, rb, 1'b1, 1'b0);
      wait_done(1'b0, lat);
      check("rand_signed", product, 64'(longint'($signed(ra)) * longint'($signed(rb))));
    end
    launch(32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    wait_done(1'b0, lat);
    check("lat_unsigned_mode", 64'(lat), 64'(N));
    check("prod_unsigned_mode", product, ref_u(32'hFFFF_FFFD, 32'd7));
`endif

    // back-to-back: each launch asserts start in the cycle right after done
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: ra = '0;
        1: rb = '0;
        2: ra = '1;
        3: rb = 32'h8000_0000;
        default: ;
      endcase
      launch(ra, rb, 1'b0, 1'b0);
      wait_done(1'b0, lat);
      check("rand_lat", 64'(lat), 64'(N));
      check("rand_prod", product, ref_u(ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
